// File: rtl/sd_ajoin_pkg.sv
// Shared constants for the n-way synchronous join: channel-count limits,
// transfer counter width and output-stage mode.
package sd_ajoin_pkg;

    localparam int CHANNELS_MIN = 2;
    localparam int CHANNELS_MAX = 8;
    localparam int XFER_CNT_W   = 16;

    typedef enum logic {
        OUT_COMB = 1'b0,
        OUT_PIPE = 1'b1
    } out_mode_e;

endpackage

// File: rtl/sd_ajoin_slot.sv
// One capture slot of the join: a valid flag plus data register that accepts
// a word whenever empty, or when the join drains it in the same cycle.
module sd_ajoin_slot #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    input  logic             clr,
    input  logic             pass,
    output logic             slot_v,
    output logic [width-1:0] slot_d
);

    assign c_drdy = ~slot_v | pass;

    // A refill in the same cycle as a drain wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v <= 1'b0;
            slot_d <= '0;
        end else if (c_srdy & c_drdy) begin
            slot_v <= 1'b1;
            slot_d <= c_data;
        end else if (clr) begin
            slot_v <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_ajoin_n.sv
// N-way synchronous join: one word from every input channel is combined into
// a single output word, with either a combinational or registered output stage.
module sd_ajoin_n
    import sd_ajoin_pkg::*;
#(
    parameter int channels = 2,
    parameter int width    = 8,
    parameter int pipe     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [channels-1:0]       c_srdy,
    output logic [channels-1:0]       c_drdy,
    input  logic [channels*width-1:0] c_data,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [channels*width-1:0] p_data,
    output logic [XFER_CNT_W-1:0]     xfer_cnt
);

    localparam out_mode_e MODE = (pipe == 1) ? OUT_PIPE : OUT_COMB;

    if (channels < CHANNELS_MIN || channels > CHANNELS_MAX) begin : g_bad_channels
        $error("sd_ajoin_n: channels=%0d outside %0d..%0d", channels, CHANNELS_MIN, CHANNELS_MAX);
    end
    if (pipe != 0 && pipe != 1) begin : g_bad_pipe
        $error("sd_ajoin_n: pipe=%0d must be 0 or 1", pipe);
    end
    if (width < 1) begin : g_bad_width
        $error("sd_ajoin_n: width=%0d must be at least 1", width);
    end

    logic [channels-1:0]       slot_v;
    logic [channels*width-1:0] slot_d;
    logic                      all_v;
    logic                      clr;
    logic                      pass;

    assign all_v = &slot_v;

    for (genvar i = 0; i < channels; i++) begin : g_slot
        sd_ajoin_slot #(.width(width)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .c_srdy (c_srdy[i]),
            .c_drdy (c_drdy[i]),
            .c_data (c_data[i*width +: width]),
            .clr    (clr),
            .pass   (pass),
            .slot_v (slot_v[i]),
            .slot_d (slot_d[i*width +: width])
        );
    end

    if (MODE == OUT_PIPE) begin : g_pipe
        logic                      load;
        logic                      ps_r;
        logic [channels*width-1:0] pd_r;

        // Loading frees every slot, so the slots may accept new data in the same cycle.
        assign load = all_v & (~ps_r | p_drdy);
        assign clr  = load;
        assign pass = load;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ps_r <= 1'b0;
                pd_r <= '0;
            end else if (load) begin
                ps_r <= 1'b1;
                pd_r <= slot_d;
            end else if (p_drdy) begin
                ps_r <= 1'b0;
            end
        end

        assign p_srdy = ps_r;
        assign p_data = pd_r;
    end else begin : g_comb
        assign clr    = all_v & p_drdy;
        assign pass   = 1'b0;
        assign p_srdy = all_v;
        assign p_data = slot_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (p_srdy & p_drdy) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_ajoin_n.sv
// Bench for sd_ajoin_n: a 2-channel combinational join and a 4-channel
// registered join checked against per-channel accepted-word queues.
module tb_sd_ajoin_n;

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  c_srdy0, c_drdy0;
    logic [15:0] c_data0, p_data0, xfer_cnt0;
    logic        p_srdy0, p_drdy0;

    logic [3:0]  c_srdy1, c_drdy1;
    logic [31:0] c_data1, p_data1;
    logic [15:0] xfer_cnt1;
    logic        p_srdy1, p_drdy1;

    int n_assert = 0;
    int n_fail   = 0;

    // Words accepted per DUT/channel, in order; rd/wr are running counts.
    logic [7:0] mem [2][4][256];
    int wr [2][4];
    int rd [2][4];
    int cnt [2];

    always #5 clk = ~clk;

    sd_ajoin_n #(.channels(2), .width(8), .pipe(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy0), .c_drdy(c_drdy0), .c_data(c_data0),
        .p_srdy(p_srdy0), .p_drdy(p_drdy0), .p_data(p_data0),
        .xfer_cnt(xfer_cnt0)
    );

    sd_ajoin_n #(.channels(4), .width(8), .pipe(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy1), .c_drdy(c_drdy1), .c_data(c_data1),
        .p_srdy(p_srdy1), .p_drdy(p_drdy1), .p_data(p_data1),
        .xfer_cnt(xfer_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                wr[d][ch] = 0;
                rd[d][ch] = 0;
            end
        end
    endtask

    // Checks handshake/data rules before an edge, then records what that edge transfers.
    task automatic observe(input int d, input int nch, input bit piped,
                           input logic [3:0] srdy, input logic [3:0] drdy, input logic [31:0] data,
                           input logic ps, input logic pd, input logic [31:0] pdata);
        int minl;
        int maxl;
        int len;
        logic [31:0] front;
        minl  = 3;
        maxl  = 0;
        front = '0;
        for (int ch = 0; ch < nch; ch++) begin
            len = wr[d][ch] - rd[d][ch];
            if (len < minl) minl = len;
            if (len > maxl) maxl = len;
            front[ch*8 +: 8] = mem[d][ch][rd[d][ch] & 255];
            if (!piped)
                chk("c_drdy_comb", 32'(drdy[ch]), 32'(len == 0));
            else if (len == 0)
                chk("c_drdy_empty", 32'(drdy[ch]), 32'd1);
            else if (len == 2 && pd !== 1'b1)
                chk("c_drdy_full", 32'(drdy[ch]), 32'd0);
        end
        if (!piped) begin
            chk("p_srdy_comb", 32'(ps), 32'(minl > 0));
        end else begin
            if (minl == 0) chk("p_srdy_empty", 32'(ps), 32'd0);
            if (maxl == 2) chk("p_srdy_held", 32'(ps), 32'd1);
        end
        if (ps === 1'b1) chk("p_data", pdata, front);
        if (ps === 1'b1 && pd === 1'b1) begin
            for (int ch = 0; ch < nch; ch++) rd[d][ch]++;
            cnt[d]++;
        end
        for (int ch = 0; ch < nch; ch++) begin
            if (srdy[ch] === 1'b1 && drdy[ch] === 1'b1) begin
                mem[d][ch][wr[d][ch] & 255] = data[ch*8 +: 8];
                wr[d][ch]++;
            end
        end
    endtask

    task automatic tick();
        #1;
        observe(0, 2, 1'b0, {2'b00, c_srdy0}, {2'b00, c_drdy0}, {16'h0, c_data0},
                p_srdy0, p_drdy0, {16'h0, p_data0});
        observe(1, 4, 1'b1, c_srdy1, c_drdy1, c_data1, p_srdy1, p_drdy1, p_data1);
        @(posedge clk);
        @(negedge clk);
        chk("xfer_cnt0", 32'(xfer_cnt0), cnt[0] & 32'hFFFF);
        chk("xfer_cnt1", 32'(xfer_cnt1), cnt[1] & 32'hFFFF);
    endtask

    initial begin
        int base;
        int guard;
        reset   = 1'b1;
        c_srdy0 = '0; c_data0 = '0; p_drdy0 = 1'b0;
        c_srdy1 = '0; c_data1 = '0; p_drdy1 = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);

        chk("rst_c_drdy0", 32'(c_drdy0), 32'h3);
        chk("rst_c_drdy1", 32'(c_drdy1), 32'hF);
        chk("rst_p_srdy0", 32'(p_srdy0), 32'd0);
        chk("rst_p_srdy1", 32'(p_srdy1), 32'd0);
        chk("rst_p_data1", p_data1, 32'd0);
        chk("rst_xfer_cnt1", 32'(xfer_cnt1), 32'd0);
        reset = 1'b0;

        // Two-channel combinational join, channels arriving a cycle apart.
        p_drdy0 = 1'b1; c_srdy0 = 2'b01; c_data0 = 16'h0011; tick();
        c_srdy0 = 2'b10; c_data0 = 16'h2200; tick();
        chk("join_p_srdy", 32'(p_srdy0), 32'd1);
        chk("join_p_data", 32'(p_data0), 32'h2211);
        c_srdy0 = 2'b00; tick();
        chk("after_join_p_srdy", 32'(p_srdy0), 32'd0);
        chk("after_join_c_drdy", 32'(c_drdy0), 32'h3);
        p_drdy0 = 1'b0;

        // Sustained streaming through the registered join.
        p_drdy1 = 1'b1; c_srdy1 = 4'hF;
        base = cnt[1];
        for (int k = 0; k < 100; k++) begin
            c_data1 = $urandom;
            tick();
        end
        chk("stream_words", cnt[1] - base, 32'd98);
        c_srdy1 = 4'h0;
        repeat (3) tick();
        chk("stream_drained", 32'(p_srdy1), 32'd0);

        // Consumer stall after the first word, then release.
        c_srdy1 = 4'hF; p_drdy1 = 1'b1;
        c_data1 = $urandom; tick();
        c_data1 = $urandom; tick();
        p_drdy1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            c_data1 = $urandom;
            tick();
        end
        chk("stall_c_drdy", 32'(c_drdy1), 32'h0);
        chk("stall_p_srdy", 32'(p_srdy1), 32'd1);
        c_srdy1 = 4'h0; p_drdy1 = 1'b1;
        base = cnt[1];
        tick(); tick();
        chk("release_two_words", cnt[1] - base, 32'd2);
        chk("release_p_srdy", 32'(p_srdy1), 32'd0);

        // Channel 2 starved while the others present data.
        c_srdy1 = 4'b1011; p_drdy1 = 1'b1;
        repeat (5) begin
            c_data1 = $urandom;
            tick();
        end
        chk("starve_c_drdy", 32'(c_drdy1), 32'b0100);
        chk("starve_p_srdy", 32'(p_srdy1), 32'd0);
        c_srdy1 = 4'b0100; c_data1 = $urandom; tick();
        c_srdy1 = 4'b0000; tick();
        chk("starve_join", 32'(p_srdy1), 32'd1);
        tick();
        chk("starve_done", 32'(p_srdy1), 32'd0);

        // Random traffic on both joins.
        for (int k = 0; k < 400; k++) begin
            c_srdy0 = 2'($urandom_range(0, 3));
            c_srdy1 = 4'($urandom_range(0, 15));
            c_data0 = 16'($urandom);
            c_data1 = $urandom;
            p_drdy0 = ($urandom_range(0, 3) != 0);
            p_drdy1 = ($urandom_range(0, 3) != 0);
            tick();
        end
        c_srdy0 = '0; c_srdy1 = '0; p_drdy0 = 1'b1; p_drdy1 = 1'b1;
        repeat (4) tick();
        chk("random_drained0", 32'(p_srdy0), 32'd0);
        chk("random_drained1", 32'(p_srdy1), 32'd0);

        // Reset with full slots and a held output word.
        c_srdy0 = 2'b11; p_drdy0 = 1'b0; c_data0 = 16'($urandom);
        c_srdy1 = 4'hF;  p_drdy1 = 1'b0; c_data1 = $urandom;
        tick(); tick();
        chk("pre_rst_p_srdy0", 32'(p_srdy0), 32'd1);
        chk("pre_rst_p_srdy1", 32'(p_srdy1), 32'd1);
        reset = 1'b1; p_drdy0 = 1'b1; p_drdy1 = 1'b1;
        #1;
        chk("mid_rst_p_srdy0", 32'(p_srdy0), 32'd0);
        chk("mid_rst_p_data0", 32'(p_data0), 32'd0);
        chk("mid_rst_p_srdy1", 32'(p_srdy1), 32'd0);
        chk("mid_rst_p_data1", p_data1, 32'd0);
        chk("mid_rst_xfer_cnt1", 32'(xfer_cnt1), 32'd0);
        @(negedge clk);
        chk("rst_edge_xfer_cnt0", 32'(xfer_cnt0), 32'd0);
        chk("rst_edge_xfer_cnt1", 32'(xfer_cnt1), 32'd0);
        chk("rst_edge_p_srdy1", 32'(p_srdy1), 32'd0);
        c_srdy0 = '0; c_srdy1 = '0; p_drdy0 = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        chk("post_rst_c_drdy0", 32'(c_drdy0), 32'h3);
        chk("post_rst_c_drdy1", 32'(c_drdy1), 32'hF);

        // Transfer counter wrap: 65537 transfers leave it at 1.
        c_srdy1 = 4'hF; p_drdy1 = 1'b1;
        guard = 0;
        while (cnt[1] < 65537 && guard < 70000) begin
            c_data1 = $urandom;
            tick();
            guard++;
        end
        chk("wrap_budget", 32'(guard < 70000), 32'd1);
        chk("wrap_xfer_cnt", 32'(xfer_cnt1), 32'h0001);
        c_srdy1 = 4'h0; p_drdy1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
